// File: rtl/fir_sched_pkg.sv
// Shared types, default geometry and saturation helpers
// for the time-multiplexed FIR MAC scheduler.
package fir_sched_pkg;

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        OUT
    } state_t;

    localparam int DEF_DATA_W   = 24;
    localparam int DEF_COEF_W   = 24;
    localparam int DEF_NUM_TAPS = 32;
    localparam int DEF_NUM_CH   = 3;
    localparam int DEF_ACC_W    = 56;

    localparam int TAP_AW = $clog2(DEF_NUM_TAPS);
    localparam int CH_W   = $clog2(DEF_NUM_CH);

    function automatic longint sat_hi(input int w);
        return (longint'(1) <<< (w - 1)) - 1;
    endfunction

    function automatic longint sat_lo(input int w);
        return -(longint'(1) <<< (w - 1));
    endfunction

    localparam longint SAT_MAX = sat_hi(DEF_DATA_W);
    localparam longint SAT_MIN = sat_lo(DEF_DATA_W);

endpackage

// File: rtl/fir_rr_arbiter.sv
// Combinational round-robin arbiter: the search starts one
// slot after the last winner and wraps modulo NUM_CH.
module fir_rr_arbiter
    import fir_sched_pkg::*;
#(
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int CW     = CH_W
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [CW-1:0]     last,
    output logic [NUM_CH-1:0] grant,
    output logic [CW-1:0]     idx
);

    function automatic int slot(input logic [CW-1:0] l, input int i);
        return (int'(l) + i) % NUM_CH;
    endfunction

    // Scan farthest-first so the nearest requester overwrites.
    always_comb begin
        grant = '0;
        idx   = '0;
        for (int i = NUM_CH; i >= 1; i--) begin
            if (req[slot(last, i)]) begin
                grant                = '0;
                grant[slot(last, i)] = 1'b1;
                idx                  = CW'(slot(last, i));
            end
        end
    end

endmodule

// File: rtl/fir_mac_scheduler.sv
// Handshake-driven FIR: one shared MAC serves NUM_CH streams,
// one result per accepted sample after NUM_TAPS MAC cycles.
module fir_mac_scheduler
    import fir_sched_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int COEF_W    = DEF_COEF_W,
    parameter int NUM_TAPS  = DEF_NUM_TAPS,
    parameter int NUM_CH    = DEF_NUM_CH,
    parameter int ACC_W     = DEF_ACC_W,
    parameter int OUT_SHIFT = 0,
    localparam int TAW = $clog2(NUM_TAPS),
    localparam int CW  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_CH-1:0]        in_valid,
    input  logic [NUM_CH*DATA_W-1:0] in_data,
    output logic [NUM_CH-1:0]        in_ready,
    input  logic                     coef_we,
    input  logic [TAW-1:0]           coef_addr,
    input  logic [COEF_W-1:0]        coef_wdata,
    output logic                     coef_ready,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [CW-1:0]            out_ch,
    output logic [DATA_W-1:0]        out_data,
    output logic                     busy
);

    localparam int PW = DATA_W + COEF_W;
    localparam logic [TAW-1:0] K_LAST = TAW'(NUM_TAPS - 1);
    localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'(sat_hi(DATA_W));
    localparam logic signed [ACC_W-1:0] SAT_LO = ACC_W'(sat_lo(DATA_W));

    state_t state;
    logic [TAW-1:0] k;
    logic [CW-1:0] cur_ch;
    logic [CW-1:0] rr_last;
    logic [CW-1:0] gnt_idx;
    logic [NUM_CH-1:0] gnt;

    logic signed [DATA_W-1:0] hist [NUM_CH][NUM_TAPS];
    logic signed [COEF_W-1:0] coef [NUM_TAPS];
    logic [TAW-1:0] wp [NUM_CH];

    logic [TAW-1:0] rd_addr;
    logic signed [PW-1:0] prod;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] acc_sum;
    logic signed [ACC_W-1:0] shifted;
    logic signed [DATA_W-1:0] sat_val;

    fir_rr_arbiter #(
        .NUM_CH(NUM_CH),
        .CW    (CW)
    ) u_arb (
        .req  (in_valid),
        .last (rr_last),
        .grant(gnt),
        .idx  (gnt_idx)
    );

    assign in_ready = (state == IDLE && !reset) ? gnt : '0;

    // Newest sample sits at wp; older taps walk backwards.
    assign rd_addr = wp[cur_ch] - k;
    assign prod    = hist[cur_ch][rd_addr] * coef[k];
    assign acc_sum = acc + {{(ACC_W - PW){prod[PW-1]}}, prod};
    assign shifted = acc_sum >>> OUT_SHIFT;

    always_comb begin
        sat_val = shifted[DATA_W-1:0];
        if (shifted > SAT_HI) begin
            sat_val = SAT_HI[DATA_W-1:0];
        end else if (shifted < SAT_LO) begin
            sat_val = SAT_LO[DATA_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (coef_we && coef_ready) begin
            coef[coef_addr] <= coef_wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            k          <= '0;
            acc        <= '0;
            cur_ch     <= '0;
            rr_last    <= CW'(NUM_CH - 1);
            out_valid  <= 1'b0;
            out_ch     <= '0;
            out_data   <= '0;
            busy       <= 1'b0;
            coef_ready <= 1'b1;
            for (int c = 0; c < NUM_CH; c++) begin
                wp[c] <= '0;
                for (int t = 0; t < NUM_TAPS; t++) begin
                    hist[c][t] <= '0;
                end
            end
        end else begin
            unique case (state)
                IDLE: begin
                    if (|in_ready) begin
                        hist[gnt_idx][wp[gnt_idx]] <=
                            in_data[gnt_idx*DATA_W +: DATA_W];
                        cur_ch     <= gnt_idx;
                        rr_last    <= gnt_idx;
                        k          <= '0;
                        acc        <= '0;
                        busy       <= 1'b1;
                        coef_ready <= 1'b0;
                        state      <= MAC;
                    end
                end
                MAC: begin
                    acc <= acc_sum;
                    k   <= k + 1'b1;
                    if (k == K_LAST) begin
                        wp[cur_ch] <= wp[cur_ch] + 1'b1;
                        out_data   <= sat_val;
                        out_ch     <= cur_ch;
                        out_valid  <= 1'b1;
                        coef_ready <= 1'b1;
                        state      <= OUT;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/fir_mac_scheduler.md
Name: fir_mac_scheduler

Overview:
- Time-multiplexed FIR controller. One multiply-accumulate unit is shared across NUM_CH input streams, with a round-robin arbiter and a valid/ready handshake on each side.
- Owns the per-channel sample history, the coefficient RAM (runtime-writable) and the tap sequencer. It produces one filtered result per accepted sample.
- Sits between the sample sources and the downstream sink. It replaces the fixed counter-driven three-path FIR with a handshake-driven schedule.

Parameters:
- DATA_W, 24, sample and output width, signed.
- COEF_W, 24, coefficient width, signed.
- NUM_TAPS, 32, taps per channel (power of 2).
- NUM_CH, 3, number of input channels.
- ACC_W, 56, accumulator width. Must be at least DATA_W+COEF_W+log2(NUM_TAPS).
- OUT_SHIFT, 0, arithmetic right shift applied to the accumulator before saturation.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  NUM_CH  per-channel sample valid.
- in_data  in  NUM_CH*DATA_W  channel c occupies bits [c*DATA_W +: DATA_W].
- in_ready  out  NUM_CH  per-channel ready; at most one bit high per cycle.
- coef_we  in  1  coefficient write strobe.
- coef_addr  in  log2(NUM_TAPS)  tap index.
- coef_wdata  in  COEF_W  coefficient value.
- coef_ready  out  1  high when a coefficient write will be accepted.
- out_valid  out  1  result valid.
- out_ready  in  1  sink ready.
- out_ch  out  log2(NUM_CH)  channel index of the result.
- out_data  out  DATA_W  saturated result.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Clock and reset: single clock clk. Reset is asynchronous and active-high.
- Values held in reset: state=IDLE, every history entry=0, every write pointer=0, acc=0, tap counter=0, rr_last=NUM_CH-1, out_valid=0, out_ch=0, out_data=0, in_ready=0, busy=0, coef_ready=1.
- Coefficient RAM is not cleared by reset. A testbench must load it after reset.
- FSM states: IDLE, MAC, OUT.
- IDLE: the arbiter searches channels starting at rr_last+1 (modulo NUM_CH) and selects the first with in_valid high. in_ready is driven combinationally for the selected channel only.
- Accepting a sample (in_valid&in_ready for channel g):
  - write the sample to hist[g][wp[g]];
  - set cur_ch=g, rr_last=g, k=0, acc=0;
  - go to MAC.
- MAC: lasts exactly NUM_TAPS cycles, k=0..NUM_TAPS-1.
  - Each cycle: acc += hist[cur][(wp[cur]-k) mod NUM_TAPS] * coef[k], in full signed precision, sign-extended to ACC_W.
  - On the cycle with k==NUM_TAPS-1: increment wp[cur] (wrapping), load out_data/out_ch, set out_valid=1, go to OUT.
- OUT: hold out_valid, out_data and out_ch stable until out_valid&out_ready. Then clear out_valid and return to IDLE.
  - A new sample is not accepted in the same cycle; earliest acceptance is the next cycle.
- Latency: a sample accepted at edge T gives out_valid high after edge T+NUM_TAPS.
  - Throughput is one result per NUM_TAPS+2 cycles when out_ready is held high.
- Output arithmetic: r = acc >>> OUT_SHIFT (arithmetic shift).
  - Saturate r to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
  - No wrap-around is allowed.
- Coefficient writes:
  - coef_ready = (state != MAC).
  - coef_we while coef_ready writes coef[coef_addr] at the clock edge.
  - coef_we during MAC is dropped silently. It must not corrupt the running sum.
- Simultaneous events:
  - A coefficient write and a sample accept in the same cycle are both performed. The first MAC cycle reads the updated coefficient.
  - Multiple in_valid bits high: only the round-robin winner is accepted. Losers stay pending and keep their data stable (standard valid/ready rule).
- Reset mid-operation: the in-flight sum is discarded and no out_valid is produced. Histories return to zero.
- History wrap-around: write pointer NUM_TAPS-1 wraps to 0. Tap read addresses wrap modulo NUM_TAPS.

Decomposition:
- Package fir_sched_pkg holds:
  - state enum {IDLE, MAC, OUT};
  - localparams TAP_AW=$clog2(NUM_TAPS) and CH_W=$clog2(NUM_CH);
  - saturation bounds.
- One natural sub-module: fir_rr_arbiter (NUM_CH requesters, rr_last input, one-hot grant plus index, combinational).
- History memory, coefficient memory and MAC stay in the top level.

Test Plan:
- Identity: coef[0]=1, all other coefficients 0. Send ch0 sample 0x00_1234 → out_data=0x001234, out_ch=0, out_valid rises exactly NUM_TAPS cycles after accept.
- Impulse response: coef[k]=k+1. Send ch1 samples 1, 0, 0, 0 → outputs 1, 2, 3, 4 on out_ch=1. ch0 and ch2 histories are untouched; a ch2 sample of 5 then yields 5.
- Round-robin: first load coefficients (identity). Assert all three in_valid together with data 10, 20, 30 → out_ch order 0, 1, 2 with data 10, 20, 30. Holding all valid again continues 0, 1, 2.
- Saturation: coef[0]=0x7FFFFF, sample 0x7FFFFF, OUT_SHIFT=0 → out_data=0x7FFFFF. A negative sample 0x800000 with coef[0]=0x7FFFFF gives out_data=0x800000 (clamped).
- Backpressure and coef lockout:
  - hold out_ready low 5 cycles in OUT → out_valid, out_data and out_ch stay stable and in_ready=0;
  - a coef_we pulsed during MAC leaves that result unchanged.
- Reset mid-MAC: assert reset at k=10 → out_valid stays 0, busy=0 on the next cycle. With coefficient RAM still programmed for identity, a fresh ch0 sample 7 gives 7.
